// File: rtl/decode_operand_stage_if.sv
// decode_operand_stage_if: handshake, writeback and result bundle of the decode/operand stage.
//   master (fetch/writeback/execute side) drives in_valid, in_inst, in_flush, wr_en, wr_addr,
//   wr_data, out_ready; slave (the stage) drives in_ready, out_valid, out_opcode, out_rd,
//   out_imm, out_rs1_data, out_rs2_data.
interface decode_operand_stage_if #(
  parameter int DATA_W   = 16,
  parameter int OPC_W    = 4,
  parameter int NUM_REGS = 16
);
  localparam int REG_AW = $clog2(NUM_REGS);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_inst;
  logic              in_flush;
  logic              wr_en;
  logic [REG_AW-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              out_valid;
  logic              out_ready;
  logic [OPC_W-1:0]  out_opcode;
  logic [REG_AW-1:0] out_rd;
  logic [DATA_W-1:0] out_imm;
  logic [DATA_W-1:0] out_rs1_data;
  logic [DATA_W-1:0] out_rs2_data;
  modport master (
    output in_valid, in_inst, in_flush, wr_en, wr_addr, wr_data, out_ready,
    input  in_ready, out_valid, out_opcode, out_rd, out_imm, out_rs1_data, out_rs2_data
  );
  modport slave (
    input  in_valid, in_inst, in_flush, wr_en, wr_addr, wr_data, out_ready,
    output in_ready, out_valid, out_opcode, out_rd, out_imm, out_rs1_data, out_rs2_data
  );
endinterface

// File: rtl/decode_operand_stage.sv
// decode_operand_stage: decode/operand-fetch pipeline stage with internal register file.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (clears register file and output bundle)
//   bus   : decode_operand_stage_if.slave (fetch handshake, writeback port, execute bundle)
//   Optional macro DECODE_FORWARD_EN: same-cycle writes forward into captured and stalled operands.
module decode_operand_stage #(
  parameter int DATA_W   = 16,
  parameter int OPC_W    = 4,
  parameter int NUM_REGS = 16,
  parameter bit R0_ZERO  = 1'b1
) (
  input logic clk,
  input logic rst_n,
  decode_operand_stage_if.slave bus
);
  localparam int REG_AW = $clog2(NUM_REGS);
  if (OPC_W + 3 * REG_AW != DATA_W) begin : g_bad_cfg
    $error("decode_operand_stage: OPC_W + 3*REG_AW must equal DATA_W");
  end
  logic [DATA_W-1:0] r_rf [NUM_REGS];
  logic              r_valid;
  logic [OPC_W-1:0]  r_opcode;
  logic [REG_AW-1:0] r_rd;
  logic [DATA_W-1:0] r_imm;
  logic [DATA_W-1:0] r_rs1_data;
  logic [DATA_W-1:0] r_rs2_data;
`ifdef DECODE_FORWARD_EN
  logic [REG_AW-1:0] r_rs1;
  logic [REG_AW-1:0] r_rs2;
`endif
  logic              w_capture;
  logic              w_wr_ok;
  logic [REG_AW-1:0] w_rd;
  logic [REG_AW-1:0] w_rs1;
  logic [REG_AW-1:0] w_rs2;
  logic [DATA_W-1:0] w_rs1_val;
  logic [DATA_W-1:0] w_rs2_val;
  assign bus.in_ready     = !r_valid | bus.out_ready;
  assign bus.out_valid    = r_valid;
  assign bus.out_opcode   = r_opcode;
  assign bus.out_rd       = r_rd;
  assign bus.out_imm      = r_imm;
  assign bus.out_rs1_data = r_rs1_data;
  assign bus.out_rs2_data = r_rs2_data;
  assign w_capture = bus.in_valid & bus.in_ready;
  assign w_rd      = bus.in_inst[3*REG_AW-1 -: REG_AW];
  assign w_rs1     = bus.in_inst[2*REG_AW-1 -: REG_AW];
  assign w_rs2     = bus.in_inst[REG_AW-1:0];
  // A write to r0 is a no-op when r0 is hardwired, so it must neither land nor forward.
  assign w_wr_ok   = bus.wr_en & !(R0_ZERO && bus.wr_addr == '0);
  always_comb begin
    w_rs1_val = (R0_ZERO && w_rs1 == '0) ? '0 : r_rf[w_rs1];
    w_rs2_val = (R0_ZERO && w_rs2 == '0) ? '0 : r_rf[w_rs2];
`ifdef DECODE_FORWARD_EN
    w_rs1_val = (w_wr_ok && bus.wr_addr == w_rs1) ? bus.wr_data : w_rs1_val;
    w_rs2_val = (w_wr_ok && bus.wr_addr == w_rs2) ? bus.wr_data : w_rs2_val;
`endif
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) r_rf[i] <= '0;
    end else if (w_wr_ok) begin
      r_rf[bus.wr_addr] <= bus.wr_data;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid    <= 1'b0;
      r_opcode   <= '0;
      r_rd       <= '0;
      r_imm      <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
`ifdef DECODE_FORWARD_EN
      r_rs1      <= '0;
      r_rs2      <= '0;
`endif
    end else begin
      // A capture wins over flush: only the previously held bundle is dropped.
      r_valid <= w_capture | (r_valid & !bus.in_flush & !bus.out_ready);
      if (w_capture) begin
        r_opcode   <= bus.in_inst[DATA_W-1 -: OPC_W];
        r_rd       <= w_rd;
        r_imm      <= {{(DATA_W-2*REG_AW){bus.in_inst[2*REG_AW-1]}}, bus.in_inst[2*REG_AW-1:0]};
        r_rs1_data <= w_rs1_val;
        r_rs2_data <= w_rs2_val;
`ifdef DECODE_FORWARD_EN
        r_rs1      <= w_rs1;
        r_rs2      <= w_rs2;
      end else if (r_valid & !bus.out_ready) begin
        if (w_wr_ok && bus.wr_addr == r_rs1) r_rs1_data <= bus.wr_data;
        if (w_wr_ok && bus.wr_addr == r_rs2) r_rs2_data <= bus.wr_data;
`endif
      end
    end
  end
endmodule
